// File: rtl/activation_requantizer.sv
// activation_requantizer: captures 1.1.14 lane sums, applies activation, rounds/saturates to 1.0.7, LPC lanes per cycle
module activation_requantizer #(
  parameter int LANES = 32,
  parameter int LPC = 4,
  parameter int ACT_MODE = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ena,
  input  logic [16*LANES-1:0]  sums_in,
  output logic [8*LANES-1:0]   acts,
  output logic                 busy,
  output logic                 done
);
  localparam int N_GRP = LANES / LPC;
  localparam int GW = N_GRP > 1 ? $clog2(N_GRP) : 1;
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t state, state_nx;
  logic [GW-1:0] grp;
  logic [16*LANES-1:0] cap;
  logic [8*LANES-1:0] stage, stage_nx;
  logic last;
  function automatic logic [7:0] requant(input logic [15:0] x);
    logic signed [17:0] xs, t_id, t_hs;
    xs = 18'(signed'(x));
    t_id = (xs + 18'sd64) >>> 7;
    t_hs = ((xs + 18'sd256) >>> 9) + 18'sd64;
    if (ACT_MODE == 2) return t_hs < 18'sd0 ? 8'h00 : t_hs > 18'sd127 ? 8'h7f : t_hs[7:0];
    if (ACT_MODE == 1 && xs < 18'sd0) return 8'h00;
    return t_id < -18'sd128 ? 8'h80 : t_id > 18'sd127 ? 8'h7f : t_id[7:0];
  endfunction
  assign last = grp == GW'(N_GRP - 1);
  assign busy = state != S_IDLE;
  always_comb begin
    stage_nx = stage;
    for (int j = 0; j < LPC; j++)
      stage_nx[(int'(grp) * LPC + j) * 8 +: 8] = requant(cap[(int'(grp) * LPC + j) * 16 +: 16]);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == S_IDLE ? (ena ? S_RUN : S_IDLE) :
               state == S_RUN  ? (last ? S_DONE : S_RUN) : S_IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      grp <= '0;
      cap <= '0;
      stage <= '0;
      acts <= '0;
      done <= 1'b0;
    end else begin
      state <= state_nx;
      done <= state == S_RUN && last;
      if (state == S_IDLE && ena) begin
        cap <= sums_in;
        grp <= '0;
      end
      if (state == S_RUN) begin
        stage <= stage_nx;
        grp <= last ? '0 : grp + GW'(1);
        if (last) acts <= stage_nx;
      end
    end
  end
endmodule
